// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared types and constants for the key_search brute-force controller.
//   state_t        : key_search FSM state encoding
//   KEY_W / ADDR_W : key and decrypted-message address widths
//   CHAR_*         : printable range accepted in a decrypted message
//   is_valid_char  : 1 when a byte is a lowercase letter or a space
// ---------------------------------------------------------------------------
package ksa_pkg;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;

    localparam logic [7:0] CHAR_LO = 8'h61;  // 'a'
    localparam logic [7:0] CHAR_HI = 8'h7A;  // 'z'
    localparam logic [7:0] CHAR_SP = 8'h20;  // ' '

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DEC,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_CHECK,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_FAIL
    } state_t;

    function automatic logic is_valid_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/key_search.sv
// ---------------------------------------------------------------------------
// key_search
// Walks candidate keys 0..KEY_MAX. For each key it pulses restart to rerun the
// init/KSA/decrypt chain, waits for dec_done, then reads MSG_LEN bytes of the
// decrypted message and accepts the key when every byte is 'a'..'z' or space.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   pulse: begin search at key 0 (honoured in IDLE/FOUND/FAIL)
//   dec_done    in   level: current key's message is present in DM
//   restart     out  one-cycle pulse: rerun the decrypt chain with key
//   key         out  current candidate key
//   addr_dec    out  DM read address
//   rddata_dec  in   DM read data, valid one cycle after addr_dec
//   busy        out  search in progress
//   found       out  key holds a valid key
//   exhausted   out  no key in 0..KEY_MAX was valid
//
// Configuration macro
//   KEY_SEARCH_EARLY_ABORT_EN : when defined, a key is dropped at its first
//   invalid byte; otherwise the full message is always scanned and a sticky
//   flag decides the outcome. Results are identical, only latency differs.
// ---------------------------------------------------------------------------
module key_search
    import ksa_pkg::*;
#(
    parameter int               MSG_LEN = 32,
    parameter logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dec_done,
    output logic              restart,
    output logic [KEY_W-1:0]  key,
    output logic [ADDR_W-1:0] addr_dec,
    input  logic [7:0]        rddata_dec,
    output logic              busy,
    output logic              found,
    output logic              exhausted
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t              state_q;
    logic [KEY_W-1:0]    key_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                invalid_q;     // some byte of this key's message was invalid
    logic                first_wait_q;  // first WAIT_DEC cycle: dec_done may be stale

    logic char_ok;
    logic last_byte;

    assign char_ok   = is_valid_char(rddata_dec);
    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            idx_q        <= '0;
            invalid_q    <= 1'b0;
            first_wait_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        state_q <= ST_LAUNCH;
                        key_q   <= '0;
                    end
                end
                ST_LAUNCH: begin
                    state_q      <= ST_WAIT_DEC;
                    first_wait_q <= 1'b1;
                    invalid_q    <= 1'b0;
                    idx_q        <= '0;
                end
                ST_WAIT_DEC: begin
                    // dec_done may still be high from the previous key on the
                    // cycle right after restart, so it is ignored once.
                    if (first_wait_q) begin
                        first_wait_q <= 1'b0;
                    end else if (dec_done) begin
                        state_q <= ST_RD_ADDR;
                        idx_q   <= '0;
                    end
                end
                ST_RD_ADDR: state_q <= ST_RD_WAIT;
                ST_RD_WAIT: state_q <= ST_CHECK;
                ST_CHECK: begin
                    invalid_q <= invalid_q | ~char_ok;
`ifdef KEY_SEARCH_EARLY_ABORT_EN
                    if (!char_ok) begin
                        state_q <= ST_NEXT_KEY;
                    end else if (last_byte) begin
                        state_q <= invalid_q ? ST_NEXT_KEY : ST_FOUND;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_RD_ADDR;
                    end
`else
                    if (last_byte) begin
                        state_q <= (invalid_q || !char_ok) ? ST_NEXT_KEY : ST_FOUND;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_RD_ADDR;
                    end
`endif
                end
                ST_NEXT_KEY: begin
                    if (key_q == KEY_MAX) begin
                        state_q <= ST_FAIL;
                    end else begin
                        key_q   <= key_q + 1'b1;
                        state_q <= ST_LAUNCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign restart   = (state_q == ST_LAUNCH);
    assign key       = key_q;
    assign found     = (state_q == ST_FOUND);
    assign exhausted = (state_q == ST_FAIL);
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_FOUND) || (state_q == ST_FAIL));
    assign addr_dec  = ((state_q == ST_RD_ADDR) || (state_q == ST_RD_WAIT) || (state_q == ST_CHECK))
                       ? idx_q : '0;

endmodule

// File: tb/tb_key_search.sv
// ---------------------------------------------------------------------------
// tb_key_search
// Directed bench for key_search. Two instances: u_dut0 with default
// parameters and u_dut1 with KEY_MAX=2. Each has a behavioural decrypt-chain
// model (dec_done 4 cycles after restart, or held high) and a registered DM
// whose contents depend on the scenario and the current key.
// ---------------------------------------------------------------------------
module tb_key_search;

    localparam int SC_FIND  = 0;  // only key 3 decrypts to all-valid text
    localparam int SC_NONE  = 1;  // every byte 8'h7B for every key
    localparam int SC_ABORT = 2;  // key 0 byte 0 is 8'h7B, rest valid
    localparam int SC_BOUND = 3;  // key 0 byte 10 is bchar, rest valid

`ifdef KEY_SEARCH_EARLY_ABORT_EN
    localparam int ABORT_PERIOD = 9;
    localparam int HOLD_PERIOD  = 7;
`else
    localparam int ABORT_PERIOD = 102;
    localparam int HOLD_PERIOD  = 100;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        dec_done0, dec_done1;
    logic        restart0, restart1;
    logic [23:0] key0, key1;
    logic [7:0]  addr0, addr1;
    logic [7:0]  rd0, rd1;
    logic        busy0, busy1, found0, found1, exh0, exh1;

    int          scenario = SC_FIND;
    logic        hold_mode = 1'b0;
    logic [7:0]  bchar = 8'h61;
    logic [7:0]  msg_mem [32];
    int          cnt0, cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    key_search u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .dec_done(dec_done0),
        .restart(restart0), .key(key0), .addr_dec(addr0), .rddata_dec(rd0),
        .busy(busy0), .found(found0), .exhausted(exh0)
    );

    key_search #(.MSG_LEN(32), .KEY_MAX(24'd2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .dec_done(dec_done1),
        .restart(restart1), .key(key1), .addr_dec(addr1), .rddata_dec(rd1),
        .busy(busy1), .found(found1), .exhausted(exh1)
    );

    function automatic logic [7:0] dm_byte(input logic [23:0] k, input logic [7:0] a);
        logic [7:0] m;
        m = msg_mem[a[4:0]];
        case (scenario)
            SC_FIND:  return (k == 24'd3 || a != 8'd5) ? m : 8'h41;
            SC_NONE:  return 8'h7B;
            SC_ABORT: return (k == 24'd0 && a == 8'd0) ? 8'h7B : m;
            default:  return (k == 24'd0 && a == 8'd10) ? bchar : m;
        endcase
    endfunction

    // Decrypt-chain and DM models.
    always @(posedge clk) begin
        if (reset) begin
            cnt0      <= 0;
            dec_done0 <= hold_mode;
        end else if (restart0) begin
            cnt0      <= 3;
            dec_done0 <= hold_mode;
        end else if (cnt0 != 0) begin
            cnt0 <= cnt0 - 1;
            if (cnt0 == 1) dec_done0 <= 1'b1;
        end
        rd0 <= dm_byte(key0, addr0);
    end

    always @(posedge clk) begin
        if (reset) begin
            cnt1      <= 0;
            dec_done1 <= hold_mode;
        end else if (restart1) begin
            cnt1      <= 3;
            dec_done1 <= hold_mode;
        end else if (cnt1 != 0) begin
            cnt1 <= cnt1 - 1;
            if (cnt1 == 1) dec_done1 <= 1'b1;
        end
        rd1 <= dm_byte(key1, addr1);
    end

    task automatic do_reset();
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic test_reset();
        scenario = SC_FIND; hold_mode = 1'b0;
        do_reset();
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy0); end
        tests_run++; if (found0 !== 1'b0) begin tests_failed++; $display("FAIL reset_found got %b want 0", found0); end
        tests_run++; if (exh0 !== 1'b0) begin tests_failed++; $display("FAIL reset_exhausted got %b want 0", exh0); end
        tests_run++; if (restart0 !== 1'b0) begin tests_failed++; $display("FAIL reset_restart got %b want 0", restart0); end
        tests_run++; if (key0 !== 24'd0) begin tests_failed++; $display("FAIL reset_key got %h want 0", key0); end
        tests_run++; if (addr0 !== 8'd0) begin tests_failed++; $display("FAIL reset_addr got %h want 0", addr0); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_find_and_restart();
        logic [23:0] keys [8];
        int n = 0;
        int cyc = 0;
        scenario = SC_FIND; hold_mode = 1'b0;
        do_reset();
        pulse_start0();
        while (!found0 && !exh0 && cyc < 3000) begin
            if (restart0) begin
                if (n < 8) keys[n] = key0;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL find_restart_count got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i < n && keys[i] !== 24'(i)) begin
                tests_failed++; $display("FAIL find_restart_key%0d got %h want %h", i, keys[i], 24'(i));
            end
        end
        tests_run++; if (found0 !== 1'b1) begin tests_failed++; $display("FAIL find_found got %b want 1", found0); end
        tests_run++; if (key0 !== 24'h3) begin tests_failed++; $display("FAIL find_key got %h want 3", key0); end
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL find_busy got %b want 0", busy0); end
        // Hold in FOUND
        repeat (3) @(posedge clk); #1;
        tests_run++; if (found0 !== 1'b1 || key0 !== 24'h3) begin tests_failed++; $display("FAIL found_hold got found=%b key=%h want 1/3", found0, key0); end
        $display("[TB] test_find restarts=%0d key=%h", n, key0);

        // start in FOUND relaunches at key 0
        pulse_start0();
        tests_run++; if (restart0 !== 1'b1) begin tests_failed++; $display("FAIL relaunch_restart got %b want 1", restart0); end
        tests_run++; if (key0 !== 24'd0) begin tests_failed++; $display("FAIL relaunch_key got %h want 0", key0); end
        tests_run++; if (found0 !== 1'b0 || busy0 !== 1'b1) begin tests_failed++; $display("FAIL relaunch_flags got found=%b busy=%b want 0/1", found0, busy0); end

        // start while busy (in WAIT_DEC of key 1) is ignored
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!(restart0 && key0 == 24'd1) && cyc < 400);
        @(posedge clk); #1;
        pulse_start0();
        tests_run++; if (restart0 !== 1'b0) begin tests_failed++; $display("FAIL busy_start_restart got %b want 0", restart0); end
        tests_run++; if (key0 !== 24'd1) begin tests_failed++; $display("FAIL busy_start_key got %h want 1", key0); end
        tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL busy_start_busy got %b want 1", busy0); end
        $display("[TB] test_start_in_found_and_busy done");
    endtask

    task automatic test_reset_mid_search();
        int cyc = 0;
        scenario = SC_NONE; hold_mode = 1'b0;
        do_reset();
        pulse_start0();
        while (!(restart0 && key0 == 24'd5) && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;  // first WAIT_DEC cycle for key 5
        tests_run++; if (key0 !== 24'd5 || busy0 !== 1'b1) begin tests_failed++; $display("FAIL midreset_pre got key=%h busy=%b want 5/1", key0, busy0); end
        reset = 1'b1;
        start0 = 1'b1;  // reset must win over start
        @(posedge clk); #1;
        tests_run++; if (key0 !== 24'd0) begin tests_failed++; $display("FAIL midreset_key got %h want 0", key0); end
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy got %b want 0", busy0); end
        tests_run++; if (restart0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_restart got %b want 0", restart0); end
        tests_run++; if (found0 !== 1'b0 || exh0 !== 1'b0 || addr0 !== 8'd0) begin tests_failed++; $display("FAIL midreset_outs got found=%b exh=%b addr=%h want 0/0/0", found0, exh0, addr0); end
        reset = 1'b0;
        start0 = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (busy0 !== 1'b0 || restart0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_idle got busy=%b restart=%b want 0/0", busy0, restart0); end
        $display("[TB] test_reset_mid_search done");
    endtask

    task automatic test_exhaust();
        int n = 0;
        int cyc = 0;
        scenario = SC_NONE; hold_mode = 1'b0;
        do_reset();
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        while (!exh1 && !found1 && cyc < 2000) begin
            if (restart1) n++;
            @(posedge clk); #1; cyc++;
        end
        tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL exhaust_restarts got %0d want 3", n); end
        tests_run++; if (exh1 !== 1'b1) begin tests_failed++; $display("FAIL exhaust_flag got %b want 1", exh1); end
        tests_run++; if (key1 !== 24'h2) begin tests_failed++; $display("FAIL exhaust_key got %h want 2", key1); end
        tests_run++; if (found1 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL exhaust_outs got found=%b busy=%b want 0/0", found1, busy1); end
        $display("[TB] test_exhaust restarts=%0d key=%h", n, key1);
    endtask

    task automatic test_period(input int sc, input logic hold, input int want, input string name);
        int cyc = 0;
        scenario = sc; hold_mode = hold;
        do_reset();
        pulse_start0();  // restart now high for key 0
        do begin @(posedge clk); #1; cyc++; end while (!restart0 && cyc < 400);
        tests_run++; if (cyc !== want) begin tests_failed++; $display("FAIL %s_period got %0d want %0d", name, cyc, want); end
        tests_run++; if (key0 !== 24'd1) begin tests_failed++; $display("FAIL %s_nextkey got %h want 1", name, key0); end
        $display("[TB] test_%s restart-to-restart=%0d", name, cyc);
    endtask

    task automatic test_boundary_chars();
        logic [7:0] chars [6];
        logic       ok [6];
        chars[0] = 8'h60; ok[0] = 1'b0;
        chars[1] = 8'h7B; ok[1] = 1'b0;
        chars[2] = 8'h1F; ok[2] = 1'b0;
        chars[3] = 8'h61; ok[3] = 1'b1;
        chars[4] = 8'h7A; ok[4] = 1'b1;
        chars[5] = 8'h20; ok[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int cyc = 0;
            scenario = SC_BOUND; hold_mode = 1'b0; bchar = chars[i];
            do_reset();
            pulse_start0();
            while (!found0 && !exh0 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
            tests_run++;
            if (found0 !== 1'b1 || key0 !== (ok[i] ? 24'd0 : 24'd1)) begin
                tests_failed++;
                $display("FAIL boundary_%h got found=%b key=%h want 1/%h", chars[i], found0, key0, ok[i] ? 24'd0 : 24'd1);
            end
            $display("[TB] test_boundary char=%h found_key=%h", chars[i], key0);
        end
    endtask

    initial begin
        string msg_str;
        msg_str = "attack at dawn the quick brown f";
        for (int i = 0; i < 32; i++) msg_mem[i] = msg_str[i];
        test_reset();
        test_find_and_restart();
        test_reset_mid_search();
        test_exhaust();
        test_period(SC_ABORT, 1'b0, ABORT_PERIOD, "abort_latency");
        test_period(SC_NONE, 1'b1, HOLD_PERIOD, "stale_done");
        test_boundary_chars();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d tests", tests_run);
        $fatal(1, "timeout");
    end

endmodule
